// File: rtl/instr_loader.sv
// Byte-stream loader for the instruction RAM: a length byte, then low/high byte pairs,
// each pair written as one word on a single-port write interface starting at address 0.
//
// state | meaning
// IDLE  | waiting for Start after reset
// LEN   | accepting the length byte (0 means a full memory)
// LO    | accepting the low byte of the next word
// HI    | accepting the high byte of the next word
// WR    | one-cycle write strobe to the instruction RAM
// DONE  | program written; outputs hold until Start
module instr_loader #(
   parameter int D = 8,
   parameter int C = 9
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [7:0]   InByte,
   input  logic         InValid,
   output logic         InReady,
   output logic         WrEn,
   output logic [D-1:0] WrAddr,
   output logic [C-1:0] WrData,
   output logic         Busy,
   output logic         Done,
   output logic [D:0]   Count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_LO,
      S_HI,
      S_WR,
      S_DONE
   } state_t;

   state_t         r_state;
   logic           r_in_ready;
   logic           r_wr_en;
   logic [D-1:0]   r_wr_addr;
   logic [C-1:0]   r_wr_data;
   logic           r_busy;
   logic           r_done;
   logic [D:0]     r_count;
   logic [D:0]     r_len;
   logic [7:0]     r_lo;

   logic           w_xfer;
   logic [D:0]     w_len_in;
   logic [D:0]     w_count_nxt;

   assign w_xfer      = InValid & r_in_ready;
   // A zero length byte stands for a completely filled memory.
   assign w_len_in    = (InByte == 8'd0) ? {1'b1, {D{1'b0}}} : (D+1)'(InByte);
   assign w_count_nxt = r_count + {{D{1'b0}}, 1'b1};

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_count    <= '0;
         r_len      <= '0;
         r_lo       <= '0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (Start) begin
                  r_state    <= S_LEN;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_count    <= '0;
                  r_wr_addr  <= '0;
               end
            end
            S_LEN: begin
               if (w_xfer) begin
                  r_len   <= w_len_in;
                  r_state <= S_LO;
               end
            end
            S_LO: begin
               if (w_xfer) begin
                  r_lo    <= InByte;
                  r_state <= S_HI;
               end
            end
            S_HI: begin
               if (w_xfer) begin
                  r_wr_data  <= {InByte[C-9:0], r_lo};
                  r_wr_en    <= 1'b1;
                  r_in_ready <= 1'b0;
                  r_state    <= S_WR;
               end
            end
            S_WR: begin
               r_count   <= w_count_nxt;
               r_wr_addr <= r_wr_addr + {{(D-1){1'b0}}, 1'b1};
               if (w_count_nxt == r_len) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state    <= S_LO;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

   assign InReady = r_in_ready;
   assign WrEn    = r_wr_en;
   assign WrAddr  = r_wr_addr;
   assign WrData  = r_wr_data;
   assign Busy    = r_busy;
   assign Done    = r_done;
   assign Count   = r_count;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued as the high byte of
// each word is driven and matched against every WrEn strobe seen on the falling edge.
module tb_instr_loader;
   localparam int D = 8;
   localparam int C = 9;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         Start;
   logic [7:0]   InByte;
   logic         InValid;
   logic         InReady;
   logic         WrEn;
   logic [D-1:0] WrAddr;
   logic [C-1:0] WrData;
   logic         Busy;
   logic         Done;
   logic [D:0]   Count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [D+C-1:0] sb[$];
   logic [D+C-1:0] sb_exp;

   instr_loader #(.D(D), .C(C)) u_dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .InByte(InByte), .InValid(InValid),
      .InReady(InReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
      .Busy(Busy), .Done(Done), .Count(Count)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (WrEn) begin
         check_eq("rdy_in_wr", InReady, 0);
         if (sb.size() == 0) begin
            check_eq("extra_wr", WrEn, 0);
         end else begin
            sb_exp = sb.pop_front();
            check_eq("wr_addr", WrAddr, sb_exp[D+C-1:C]);
            check_eq("wr_data", WrData, sb_exp[C-1:0]);
         end
      end
   end

   // All tasks are entered and left on a falling edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      repeat (gap) @(negedge Clk);
      InByte  = b;
      InValid = 1'b1;
      while (!InReady && n < 100) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 100) check_eq("rdy_timeout", InReady, 1);
      @(negedge Clk);
      InValid = 1'b0;
   endtask

   task automatic send_word(input logic [D-1:0] addr, input logic [7:0] lo, input logic [7:0] hi,
                            input int max_gap);
      logic [C-1:0] data;
      data = {hi[C-9:0], lo};
      send_byte(lo, max_gap == 0 ? 0 : int'($urandom_range(0, max_gap)));
      sb.push_back({addr, data});
      send_byte(hi, max_gap == 0 ? 0 : int'($urandom_range(0, max_gap)));
   endtask

   task automatic start_load();
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      check_eq("start_busy", Busy, 1);
      check_eq("start_count", Count, 0);
      check_eq("start_rdy", InReady, 1);
   endtask

   task automatic wait_done(input int budget, input logic [D:0] exp_count);
      int n = 0;
      while (!Done && n < budget) begin
         @(negedge Clk);
         n++;
      end
      check_eq("done", Done, 1);
      check_eq("done_busy", Busy, 0);
      check_eq("done_rdy", InReady, 0);
      check_eq("done_count", Count, exp_count);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      InValid = 1'b0;
      Start = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; InByte = 8'h00; InValid = 1'b0;
      repeat (3) @(negedge Clk);
      check_eq("rst_rdy", InReady, 0);
      check_eq("rst_wren", WrEn, 0);
      check_eq("rst_busy", Busy, 0);
      check_eq("rst_done", Done, 0);
      check_eq("rst_addr", WrAddr, 0);
      check_eq("rst_data", WrData, 0);
      check_eq("rst_count", Count, 0);
      Reset = 1'b0;
      @(negedge Clk);

      // T1: back-to-back stream
      start_load();
      send_byte(8'h03, 0);
      send_word(8'd0, 8'hA5, 8'h01, 0);
      send_word(8'd1, 8'h03, 8'h00, 0);
      send_word(8'd2, 8'h00, 8'h01, 0);
      wait_done(20, 9'd3);

      // T2: same stream with random source stalls
      for (int r = 0; r < 3; r++) begin
         start_load();
         send_byte(8'h03, $urandom_range(0, 5));
         send_word(8'd0, 8'hA5, 8'h01, 5);
         send_word(8'd1, 8'h03, 8'h00, 5);
         send_word(8'd2, 8'h00, 8'h01, 5);
         wait_done(40, 9'd3);
      end

      // T6: upper high-byte bits are dropped
      start_load();
      send_byte(8'h01, 0);
      send_word(8'd0, 8'h00, 8'hFF, 0);
      wait_done(10, 9'd1);
      check_eq("t6_data", WrData, 9'h100);

      // T3: full memory via length 0
      start_load();
      send_byte(8'h00, 0);
      for (int a = 0; a < 256; a++) send_word(a[D-1:0], a[7:0], 8'h00, 0);
      wait_done(10, 9'd256);
      repeat (4) @(negedge Clk);
      check_eq("t3_no_more_wr", WrEn, 0);

      // T5: Start in LO ignored; Start in DONE restarts at address 0
      start_load();
      send_byte(8'h02, 0);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      check_eq("t5_busy_lo", Busy, 1);
      send_word(8'd0, 8'h11, 8'h01, 0);
      send_word(8'd1, 8'h22, 8'h00, 0);
      wait_done(10, 9'd2);
      start_load();
      check_eq("t5_done_clr", Done, 0);
      check_eq("t5_addr_clr", WrAddr, 0);
      send_byte(8'h01, 0);
      send_word(8'd0, 8'h5A, 8'h00, 0);
      wait_done(10, 9'd1);

      // T4: reset during WR lets the strobe finish, then everything clears
      start_load();
      send_byte(8'h03, 0);
      send_word(8'd0, 8'h01, 8'h00, 0);
      send_word(8'd1, 8'h02, 8'h01, 0);
      check_eq("t4_wr_cycle", WrEn, 1);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check_eq("t4_wren", WrEn, 0);
      check_eq("t4_busy", Busy, 0);
      check_eq("t4_done", Done, 0);
      check_eq("t4_count", Count, 0);
      check_eq("t4_rdy", InReady, 0);

      // T4: reset in HI drops the partial word
      start_load();
      send_byte(8'h02, 0);
      send_byte(8'h77, 0);
      do_reset();
      repeat (5) @(negedge Clk);
      check_eq("t4_hi_busy", Busy, 0);
      check_eq("t4_hi_count", Count, 0);

      check_eq("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
